// File: rtl/soc_cpu0_oci_dct_packer.sv
// CPU0 OCI direct-control-trace packer: shifts 2-bit branch codes into a 30-bit frame
// and hands completed/flushed frames to the trace sink. Optional macro: SOC_DCT_OVF_COUNT_EN.
module soc_cpu0_oci_dct_packer #(
    parameter int unsigned IDLE_FLUSH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trc_on,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        flush,
    input  logic        frm_ready,
    input  logic        ovf_clr,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frm_valid,
    output logic [29:0] frm_data,
    output logic [3:0]  frm_count,
    output logic        overflow,
    output logic [7:0]  ovf_count
);

    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_FLUSH_CYCLES);

    logic [29:0] buf_reg, buf_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [29:0] frm_data_reg;
    logic [3:0]  frm_count_reg;
    logic        frm_valid_reg, frm_valid_next;
    logic        overflow_reg, overflow_next;
    logic [7:0]  idle_reg, idle_next;
    logic        trc_on_reg;

    logic        accept;
    logic [29:0] buf_acc;
    logic [3:0]  cnt_acc;
    logic        full_hit, flush_hit, fall_hit, idle_hit;
    logic        emit, load, drop;

    always_comb begin
        accept    = trc_on & dct_valid & (dct_code != 2'b00);
        buf_acc   = accept ? {buf_reg[27:0], dct_code} : buf_reg;
        cnt_acc   = cnt_reg + {3'b000, accept};

        full_hit  = accept && (cnt_acc == 4'd15);
        flush_hit = flush && (cnt_acc != 4'd0);
        fall_hit  = trc_on_reg && !trc_on && (cnt_acc != 4'd0);
        // Timeout fires on the idle cycle that makes the run length equal the limit.
        idle_hit  = (IDLE_LIMIT != 8'd0) && (cnt_reg != 4'd0) && !accept &&
                    (({1'b0, idle_reg} + 9'd1) == {1'b0, IDLE_LIMIT});
        emit      = full_hit || flush_hit || fall_hit || idle_hit;

        load      = emit && (!frm_valid_reg || frm_ready);
        drop      = emit && !load;

        buf_next  = emit ? '0 : buf_acc;
        cnt_next  = emit ? '0 : cnt_acc;

        if (load)
            frm_valid_next = 1'b1;
        else if (frm_valid_reg && frm_ready)
            frm_valid_next = 1'b0;
        else
            frm_valid_next = frm_valid_reg;

        if (emit || accept || (cnt_reg == 4'd0))
            idle_next = '0;
        else if (idle_reg != 8'hFF)
            idle_next = idle_reg + 8'd1;
        else
            idle_next = idle_reg;

        // A drop in the same cycle as ovf_clr keeps the flag set.
        if (drop)
            overflow_next = 1'b1;
        else if (ovf_clr)
            overflow_next = 1'b0;
        else
            overflow_next = overflow_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_reg       <= '0;
            cnt_reg       <= '0;
            frm_valid_reg <= 1'b0;
            frm_data_reg  <= '0;
            frm_count_reg <= '0;
            overflow_reg  <= 1'b0;
            idle_reg      <= '0;
            trc_on_reg    <= 1'b0;
        end else begin
            buf_reg       <= buf_next;
            cnt_reg       <= cnt_next;
            frm_valid_reg <= frm_valid_next;
            overflow_reg  <= overflow_next;
            idle_reg      <= idle_next;
            trc_on_reg    <= trc_on;
            if (load) begin
                frm_data_reg  <= buf_acc;
                frm_count_reg <= cnt_acc;
            end
        end
    end

`ifdef SOC_DCT_OVF_COUNT_EN
    logic [7:0] ovf_count_reg, ovf_count_next;

    always_comb begin
        if (drop) begin
            if (ovf_clr)
                ovf_count_next = 8'd1;
            else if (ovf_count_reg != 8'hFF)
                ovf_count_next = ovf_count_reg + 8'd1;
            else
                ovf_count_next = ovf_count_reg;
        end else if (ovf_clr) begin
            ovf_count_next = '0;
        end else begin
            ovf_count_next = ovf_count_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf_count_reg <= '0;
        else
            ovf_count_reg <= ovf_count_next;
    end

    assign ovf_count = ovf_count_reg;
`else
    assign ovf_count = '0;
`endif

    assign dct_buffer = buf_reg;
    assign dct_count  = cnt_reg;
    assign frm_valid  = frm_valid_reg;
    assign frm_data   = frm_data_reg;
    assign frm_count  = frm_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_soc_cpu0_oci_dct_packer.sv
// Directed bench for soc_cpu0_oci_dct_packer with a 4-cycle idle-flush limit.
module tb_soc_cpu0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trc_on;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        frm_ready;
    logic        ovf_clr;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
    logic        overflow;
    logic [7:0]  ovf_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef SOC_DCT_OVF_COUNT_EN
    localparam logic [7:0] OVF_ONE = 8'd1;
`else
    localparam logic [7:0] OVF_ONE = 8'd0;
`endif

    soc_cpu0_oci_dct_packer #(.IDLE_FLUSH_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .trc_on     (trc_on),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .flush      (flush),
        .frm_ready  (frm_ready),
        .ovf_clr    (ovf_clr),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_count  (frm_count),
        .overflow   (overflow),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " frm_valid"},  32'(frm_valid),  32'd0);
        chk({tag, " dct_count"},  32'(dct_count),  32'd0);
        chk({tag, " dct_buffer"}, 32'(dct_buffer), 32'd0);
        chk({tag, " frm_data"},   32'(frm_data),   32'd0);
        chk({tag, " frm_count"},  32'(frm_count),  32'd0);
        chk({tag, " overflow"},   32'(overflow),   32'd0);
        chk({tag, " ovf_count"},  32'(ovf_count),  32'd0);
    endtask

    initial begin
        reset = 1'b1; trc_on = 1'b1; dct_valid = 1'b0; dct_code = 2'b00;
        flush = 1'b0; frm_ready = 1'b1; ovf_clr = 1'b0;
        cyc(); cyc();
        check_all_zero("reset");
        reset = 1'b0;
        cyc();

        // Full frame of 15 taken codes
        dct_valid = 1'b1; dct_code = 2'b10;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (i == 13) chk("full cnt14", 32'(dct_count), 32'd14);
        end
        dct_valid = 1'b0;
        chk("full valid", 32'(frm_valid), 32'd1);
        chk("full data",  32'(frm_data),  32'h2AAAAAAA);
        chk("full count", 32'(frm_count), 32'd15);
        chk("full dcnt0", 32'(dct_count), 32'd0);
        cyc();
        chk("full drain", 32'(frm_valid), 32'd0);

        // Partial frame via flush, then a flush on an empty buffer
        dct_valid = 1'b1;
        dct_code = 2'b01; cyc();
        dct_code = 2'b10; cyc();
        dct_code = 2'b11; cyc();
        dct_valid = 1'b0;
        chk("part buf", 32'(dct_buffer), 32'h1B);
        chk("part cnt", 32'(dct_count),  32'd3);
        frm_ready = 1'b0; flush = 1'b1; cyc();
        chk("part valid", 32'(frm_valid), 32'd1);
        chk("part data",  32'(frm_data),  32'h1B);
        chk("part count", 32'(frm_count), 32'd3);
        chk("part dcnt0", 32'(dct_count), 32'd0);
        cyc();
        chk("noop ovf",   32'(overflow),  32'd0);
        chk("noop data",  32'(frm_data),  32'h1B);
        flush = 1'b0; frm_ready = 1'b1; cyc();
        chk("part drain", 32'(frm_valid), 32'd0);

        // Overflow: 30 not-taken codes with the sink stalled
        frm_ready = 1'b0; dct_valid = 1'b1; dct_code = 2'b01;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (i == 14) begin
                chk("ovf first valid", 32'(frm_valid), 32'd1);
                chk("ovf first data",  32'(frm_data),  32'h15555555);
            end
        end
        dct_valid = 1'b0;
        chk("ovf held data", 32'(frm_data),  32'h15555555);
        chk("ovf held cnt",  32'(frm_count), 32'd15);
        chk("ovf flag",      32'(overflow),  32'd1);
        chk("ovf count",     32'(ovf_count), 32'(OVF_ONE));
        chk("ovf dcnt0",     32'(dct_count), 32'd0);
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("ovfclr flag",  32'(overflow),  32'd0);
        chk("ovfclr count", 32'(ovf_count), 32'd0);
        // Drop coinciding with ovf_clr
        dct_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ovf_clr = (i == 14);
            cyc();
        end
        dct_valid = 1'b0; ovf_clr = 1'b0;
        chk("dropclr flag",  32'(overflow),  32'd1);
        chk("dropclr count", 32'(ovf_count), 32'(OVF_ONE));
        ovf_clr = 1'b1; frm_ready = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("dropclr clear", 32'(overflow), 32'd0);
        chk("ovf drain",     32'(frm_valid), 32'd0);

        // Idle flush after 4 idle cycles
        dct_valid = 1'b1;
        dct_code = 2'b10; cyc();
        dct_code = 2'b01; cyc();
        dct_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("idle3 valid", 32'(frm_valid), 32'd0);
        chk("idle3 dcnt",  32'(dct_count), 32'd2);
        cyc();
        chk("idle4 valid", 32'(frm_valid), 32'd1);
        chk("idle4 count", 32'(frm_count), 32'd2);
        chk("idle4 data",  32'(frm_data),  32'h9);
        // Accept during the drain cycle, then restart on idle cycle 3
        dct_valid = 1'b1; dct_code = 2'b11; cyc();
        chk("idle drain", 32'(frm_valid), 32'd0);
        dct_valid = 1'b0; cyc(); cyc();
        dct_valid = 1'b1; dct_code = 2'b01; cyc();
        dct_valid = 1'b0; cyc(); cyc(); cyc();
        chk("restart3 valid", 32'(frm_valid), 32'd0);
        chk("restart3 dcnt",  32'(dct_count), 32'd2);
        cyc();
        chk("restart4 valid", 32'(frm_valid), 32'd1);
        chk("restart4 data",  32'(frm_data),  32'hD);
        cyc();
        chk("restart drain", 32'(frm_valid), 32'd0);

        // trc_on falling edge flushes 5 codes
        dct_valid = 1'b1; dct_code = 2'b10;
        for (int i = 0; i < 5; i++) cyc();
        chk("fall dcnt5", 32'(dct_count), 32'd5);
        trc_on = 1'b0; dct_code = 2'b01; cyc();
        chk("fall valid", 32'(frm_valid), 32'd1);
        chk("fall count", 32'(frm_count), 32'd5);
        chk("fall data",  32'(frm_data),  32'h2AA);
        cyc();
        chk("off ignored", 32'(dct_count), 32'd0);
        chk("fall drain",  32'(frm_valid), 32'd0);
        trc_on = 1'b1; dct_code = 2'b00; cyc();
        chk("code00 cnt", 32'(dct_count), 32'd0);
        dct_code = 2'b10; cyc();
        dct_valid = 1'b0;
        chk("single cnt", 32'(dct_count),  32'd1);
        chk("single buf", 32'(dct_buffer), 32'h2);

        // Reset with a pending frame and 7 buffered codes
        frm_ready = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
        dct_valid = 1'b1; dct_code = 2'b11;
        for (int i = 0; i < 7; i++) cyc();
        dct_valid = 1'b0;
        chk("prerst dcnt",  32'(dct_count), 32'd7);
        chk("prerst valid", 32'(frm_valid), 32'd1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check_all_zero("midreset");
        for (int i = 0; i < 10; i++) cyc();
        chk("postrst valid", 32'(frm_valid), 32'd0);
        chk("postrst dcnt",  32'(dct_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
